uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter (`uart2` datapath inside `Uart`) among several byte producers. It accepts one byte at a time from up to `NUM_REQ` requesters over valid/ready handshakes, drives the transmitter's data and start strobe, and waits for frame completion. A watchdog flags and recovers from a transmitter that never reports completion.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width; fixed at 8 for the UART.
- `TIMEOUT_CYC`, 20000: maximum clk cycles allowed from `tx_start` to `tx_done`.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  NUM_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse: the byte is accepted.
- `tx_data`  out  8  byte presented to the transmitter; held stable until the next grant.
- `tx_start`  out  1  one-cycle pulse that launches a frame.
- `tx_done`  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- `grant_id`  out  clog2(NUM_REQ)  index of the requester whose byte is in flight.
- `busy`  out  1  high from grant until completion or timeout.
- `timeout_err`  out  1  one-cycle pulse when the watchdog expires.

## Operation
- FSM states are `IDLE`, `START` and `WAIT_DONE`.
- **IDLE:** if any `req_valid` is high:
  - Pick requester i by round-robin, starting the search at `last_grant+1` and wrapping at `NUM_REQ-1` to 0.
  - Register `tx_data <= req_data[i]`, `grant_id <= i` and `last_grant <= i`, then go to `START`.
  - If no `req_valid` is high, stay in `IDLE`.
- **START (exactly 1 cycle):**
  - `tx_start=1`, `req_ready[i]=1` and `busy=1`.
  - Clear the watchdog counter, then go to `WAIT_DONE`.
- **WAIT_DONE:**
  - `busy=1`; the counter increments each cycle.
  - On `tx_done`, go to `IDLE`.
  - When the counter reaches `TIMEOUT_CYC-1` without `tx_done`, pulse `timeout_err` and go to `IDLE`. The byte is dropped and is not retried.
- **Requester rules:**
  - Once `req_valid` is raised, the requester holds it and `req_data` stable until it sees `req_ready`.
  - The requester may drop `req_valid` in the cycle after `req_ready`, or keep it high to offer the next byte.
- **Boundary conditions:**
  - `tx_done` and watchdog expiry in the same cycle: `tx_done` wins and there is no `timeout_err`.
  - `tx_done` while in `IDLE` or `START` is ignored.
  - A requester deasserting `req_valid` before being granted simply loses its turn.
  - All requesters continuously valid: grants rotate 0,1,2,3,0,… with no requester starved.
  - Single requester continuously valid: it is granted back-to-back.
- **Reset (any state, including mid-frame):**
  - Go to `IDLE`; the watchdog counter is cleared.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - The transmitter is reset independently by the same `reset` net.

## Timing
- Reset values: `req_ready=0`, `tx_data=8'h00`, `tx_start=0`, `grant_id=0`, `busy=0`, `timeout_err=0`.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Latency from `req_valid` rising in `IDLE` (cycle N) to `tx_start`/`req_ready` is cycle N+1.
- The earliest next grant decision is the cycle after `tx_done` is sampled. Minimum per-byte overhead is 2 cycles beyond the frame time.
- Watchdog: `timeout_err` asserts exactly `TIMEOUT_CYC` cycles after the `tx_start` cycle.
- Counter width is clog2(`TIMEOUT_CYC`+1) bits. It saturates, with no wrap.

## Structure
- Shared package `uart_ctrl_pkg`:
  - FSM state enum `sched_state_t` (`IDLE`, `START`, `WAIT_DONE`).
  - Default constants `UART_DATA_W=8` and `UART_TX_TIMEOUT=20000`.
- Sub-module `rr_arbiter`:
  - Combinational pick of the next index from `req_valid` and `last_grant`.
  - Outputs `found` and `idx`.
  - Parameterised by `NUM_REQ`; reusable later for RX-buffer readers.
- The top level holds the FSM, the data/grant registers and the watchdog counter.

## Test plan
- **Reset:** assert `reset` 2 cycles mid-`WAIT_DONE` → all outputs 0 the next cycle. With requesters 0 and 2 valid after release, requester 0 is granted first.
- **Single requester:**
  - Stimulus: requester 1 valid with 8'hA5; `tx_done` 10 cycles after start.
  - Required: `tx_start` and `req_ready[1]` one cycle after valid, `tx_data=8'hA5`, `grant_id=1`, `busy` high 11 cycles.
- **Fairness:** all four requesters valid continuously with data 8'h10..8'h13 → grant order 0,1,2,3,0 and `tx_data` sequence 10,11,12,13,10.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYC=50` and `tx_done` never sent.
  - Required: `timeout_err` pulses 50 cycles after `tx_start`, the FSM returns to `IDLE`, and the next pending requester is granted.
- **Coincident events:** `tx_done` on the expiry cycle → no `timeout_err`. A stray `tx_done` in `IDLE` → no state change.
- **Valid withdrawal:** requester 3 drops valid while requester 0 is in flight → requester 3 is never granted and gets no `req_ready` pulse.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control blocks: scheduler FSM states and
// default transmitter constants.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } sched_state_t;

  localparam int UART_DATA_W     = 8;
  localparam int UART_TX_TIMEOUT = 20000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last_grant,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Offset 1 first, so last_grant itself is considered only after all others.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers,
// with a watchdog that abandons a frame whose tx_done never arrives.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int TIMEOUT_CYC = UART_TX_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_t     state, state_next;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [CNT_W-1:0] wdog_cnt;
  logic             expire;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // Counter is 0 during START, so it reads TIMEOUT_CYC-1 on the last cycle
  // before the TIMEOUT_CYC-th cycle after tx_start.
  assign expire = (state == WAIT_DONE) && (wdog_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pick_found) state_next = START;
      START:     state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done || expire) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data     <= '0;
      grant_id    <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // tx_done on the expiry cycle completes the frame normally.
      timeout_err <= expire && !tx_done;
      if (state == IDLE)                           wdog_cnt <= '0;
      else if (wdog_cnt != CNT_W'(TIMEOUT_CYC))    wdog_cnt <= wdog_cnt + CNT_W'(1);
      if (state == IDLE && pick_found) begin
        tx_data    <= req_data[pick_idx*DATA_W +: DATA_W];
        grant_id   <= pick_idx;
        last_grant <= pick_idx;
      end
    end
  end

  assign tx_start  = (state == START);
  assign busy      = (state != IDLE);
  assign req_ready = (state == START) ? (NUM_REQ'(1) << grant_id) : '0;

endmodule
